regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
Write-back controller and scoreboard for the 32x32 register file in decode. It arbitrates the single RF write port between the single-cycle ALU result path (requester A) and the long-latency load/mul-div path (requester B), and drives RegWr/write_reg/write_data from a registered stage. It tracks registers with outstanding long-latency writes and raises a decode stall on RAW/WAW hazards against them.

Parameters:
XLEN, 32, data width of write-back values
RR_EN, 1, 1 = round-robin between A and B on conflict; 0 = fixed priority to B
CNT_W, 16, width of saturating conflict counter

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk
issue_valid  input  1  decode issuing an instruction this cycle
issue_long  input  1  issued instruction writes back via requester B
issue_rd  input  5  destination register of issued instruction
rs1  input  5  decode source register 1 under check
rs2  input  5  decode source register 2 under check
rd  input  5  decode destination register under check
stall  output  1  combinational hazard stall to decode
a_valid  input  1  ALU write-back request
a_rd  input  5  ALU destination
a_data  input  XLEN  ALU result
a_ready  output  1  A granted this cycle
b_valid  input  1  long-unit write-back request
b_rd  input  5  long-unit destination
b_data  input  XLEN  long-unit result
b_ready  output  1  B granted this cycle
RegWr  output  1  RF write enable
write_reg  output  5  RF write address
write_data  output  XLEN  RF write data
pending  output  32  scoreboard bits, bit i = reg i has outstanding B write
conflict_cnt  output  CNT_W  cycles in which A and B were both valid

Behaviour:
- Reset (n_rst=0 at edge): RegWr=0, write_reg=0, write_data=0, pending=0, conflict_cnt=0, last_grant=B (A wins first conflict). Any in-flight write in the output stage is dropped; reset mid-operation loses all pending bits.
- Arbitration (combinational, same cycle): only A valid -> a_ready=1; only B valid -> b_ready=1; both valid -> RR_EN=1 grant the requester not equal to last_grant, RR_EN=0 grant B. At most one of a_ready/b_ready is 1; neither when no valid. Ready never depends on the other requester's ready. Requester holds valid/rd/data stable until its ready=1.
- last_grant updates only on a grant cycle.
- Output stage: grant at edge N loads write_reg/write_data from the winner; RegWr=1 during cycle N+1, so the RF commits at edge N+1. Latency request-to-commit = 1 cycle. No grant -> RegWr=0, write_reg/write_data hold.
- x0: a grant with rd=0 is consumed (ready=1) but RegWr=0 next cycle; pending[0] is never set.
- Scoreboard set: issue_valid & issue_long & issue_rd!=0 sets pending[issue_rd] at edge.
- Scoreboard clear: pending[write_reg] cleared at the edge where RegWr=1 and the write originated from B (origin flag registered with the output stage). A writes never clear bits.
- Set and clear of same bit at same edge: set wins.
- stall = issue_valid & (pending[rs1] | pending[rs2] | pending[rd]) with index 0 ignored. Also stall=1 when the output stage holds a B write (RegWr=1) to rs1/rs2/rd this cycle (no bypass; RF read is valid after the commit edge).
- conflict_cnt increments by 1 each cycle a_valid & b_valid; saturates at all-ones.
- Decode issues an A-path instruction with rd pending only if stall is ignored; not legal, behaviour: write commits, pending bit remains.

Test Plan:
- Reset: hold n_rst=0 two cycles with a_valid=1 -> RegWr=0, pending=0, conflict_cnt=0; release, a_rd=5 a_data=0x1234 -> cycle after grant RegWr=1 write_reg=5 write_data=0x1234.
- Conflict RR: A(rd=3,0xAA) and B(rd=4,0xBB) valid 2 cycles, then hold -> grants A then B; RegWr commits r3=0xAA then r4=0xBB; conflict_cnt=2; with RR_EN=0 order B then A.
- Scoreboard: issue_long rd=7 -> pending[7]=1; decode rs1=7 -> stall=1 until B write rd=7 commits; stall=0 on the cycle after the commit edge.
- x0: B grant with rd=0 data=0xFFFF -> b_ready=1, RegWr stays 0, pending unchanged.
- Set/clear collision: B write to r9 committing while new issue_long rd=9 -> pending[9]=1 after edge.
- Reset mid-op: pending[12]=1 and output stage loaded, assert n_rst=0 one cycle -> RegWr=0, pending=0 next cycle, no RF write occurs.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the 32x32 decode register file: arbitrates the RF write
// port between the ALU (A) and long-latency (B) paths and scoreboards outstanding B writes.
module regfile_wb_ctrl #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             issue_valid,
    input  logic             issue_long,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    output logic             stall,
    input  logic             a_valid,
    input  logic [4:0]       a_rd,
    input  logic [XLEN-1:0]  a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [4:0]       b_rd,
    input  logic [XLEN-1:0]  b_data,
    output logic             b_ready,
    output logic             RegWr,
    output logic [4:0]       write_reg,
    output logic [XLEN-1:0]  write_data,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e          last_grant;
    logic            wr_q;
    logic            wb_from_b;
    logic            grant;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic [31:0]     pending_nxt;
    logic            b_inflight;

    // NOTE: every output of a combinational block is given a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (a_valid && b_valid) begin
            if (RR_EN && (last_grant == GRANT_B)) a_ready = 1'b1;
            else                                  b_ready = 1'b1;
        end else begin
            a_ready = a_valid;
            b_ready = b_valid;
        end
    end

    assign grant    = a_ready | b_ready;
    assign win_rd   = b_ready ? b_rd   : a_rd;
    assign win_data = b_ready ? b_data : a_data;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_q       <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= '0;
            wb_from_b  <= 1'b0;
            last_grant <= GRANT_B;
        end else begin
            // A grant to x0 is consumed but never reaches the RF.
            wr_q <= grant && (win_rd != 5'd0);
            if (grant) begin
                write_reg  <= win_rd;
                write_data <= win_data;
                wb_from_b  <= b_ready;
                last_grant <= b_ready ? GRANT_B : GRANT_A;
            end
        end
    end

    // An asserted reset kills the in-flight write before its commit edge.
    assign RegWr      = wr_q & n_rst;
    assign b_inflight = RegWr & wb_from_b;

    // Clear first, then set, so a same-edge set of the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (b_inflight) pending_nxt[write_reg] = 1'b0;
        if (issue_valid && issue_long && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pending      <= '0;
            conflict_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            if (a_valid && b_valid && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    function automatic logic reg_busy(input logic [4:0]  r,
                                      input logic [31:0] pend,
                                      input logic        inflight,
                                      input logic [4:0]  wreg);
        return (r != 5'd0) && (pend[r] || (inflight && (wreg == r)));
    endfunction

    // No bypass: a source being written this cycle is readable only after the commit edge.
    assign stall = issue_valid && (reg_busy(rs1, pending, b_inflight, write_reg) ||
                                   reg_busy(rs2, pending, b_inflight, write_reg) ||
                                   reg_busy(rd,  pending, b_inflight, write_reg));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: a scoreboard queue of expected RF commits plus
// immediate-assertion checks of arbitration, scoreboard bits, stall and reset.
module tb_regfile_wb_ctrl;

    localparam int XLEN = 32;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            issue_valid, issue_long;
    logic [4:0]      issue_rd, rs1, rs2, rd;
    logic            a_valid, b_valid;
    logic [4:0]      a_rd, b_rd;
    logic [XLEN-1:0] a_data, b_data;

    logic            stall, a_ready, b_ready, RegWr;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic [31:0]     pending;
    logic [15:0]     conflict_cnt;

    logic            fp_stall, fp_a_ready, fp_b_ready, fp_RegWr;
    logic [4:0]      fp_write_reg;
    logic [XLEN-1:0] fp_write_data;
    logic [31:0]     fp_pending;
    logic [1:0]      fp_conflict_cnt;

    int  n_pass = 0;
    int  n_total = 0;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.XLEN(XLEN), .RR_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .RegWr(RegWr), .write_reg(write_reg), .write_data(write_data),
        .pending(pending), .conflict_cnt(conflict_cnt)
    );

    // Fixed-priority variant with a 2-bit counter to reach saturation quickly.
    regfile_wb_ctrl #(.XLEN(XLEN), .RR_EN(1'b0), .CNT_W(2)) u_fp (
        .clk(clk), .n_rst(n_rst),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rd(rd), .stall(fp_stall),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(fp_a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(fp_b_ready),
        .RegWr(fp_RegWr), .write_reg(fp_write_reg), .write_data(fp_write_data),
        .pending(fp_pending), .conflict_cnt(fp_conflict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [4:0] r, input logic [XLEN-1:0] d);
        wb_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Commit monitor: samples just before each rising edge, where RegWr=1 means the RF writes.
    initial begin
        forever begin
            wb_t e;
            @(negedge clk);
            #4;
            if (RegWr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected_write", {59'd0, write_reg}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd",   {59'd0, write_reg}, {59'd0, e.rd});
                    chk("wb_data", {32'd0, write_data}, {32'd0, e.data});
                end
            end
        end
    end

    initial begin
        n_rst = 1'b0;
        issue_valid = 1'b0; issue_long = 1'b0; issue_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
        b_valid = 1'b0; b_rd = 5'd0; b_data = '0;

        // Reset held two cycles with A requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_regwr",   RegWr, 1'b0);
        chk("rst_wreg",    write_reg, 5'd0);
        chk("rst_wdata",   write_data, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_cnt",     conflict_cnt, 16'd0);
        #1 n_rst = 1'b1; push(5'd5, 32'h1234);
        #1 chk("a_only_ready", {b_ready, a_ready}, 2'b01);
        @(negedge clk);
        chk("a_commit_we",   RegWr, 1'b1);
        chk("a_commit_reg",  write_reg, 5'd5);
        chk("a_commit_data", write_data, 32'h1234);
        #1 a_valid = 1'b0;
        @(negedge clk);
        #1 n_rst = 1'b0;

        // Conflict: round-robin grants A first after reset, fixed priority grants B.
        @(negedge clk);
        #1 n_rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAA;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hBB;
        push(5'd3, 32'hAA);
        #1 chk("rr_first_grant", {b_ready, a_ready}, 2'b01);
        chk("fp_first_grant", {fp_b_ready, fp_a_ready}, 2'b10);
        @(negedge clk);
        chk("rr_wr1_reg", write_reg, 5'd3);
        chk("fp_wr1_we",  fp_RegWr, 1'b1);
        chk("fp_wr1_reg", fp_write_reg, 5'd4);
        chk("fp_wr1_data", fp_write_data, 32'hBB);
        #1 a_rd = 5'd6; a_data = 32'hCC; push(5'd4, 32'hBB);
        #1 chk("rr_second_grant", {b_ready, a_ready}, 2'b10);
        @(negedge clk);
        chk("rr_wr2_reg", write_reg, 5'd4);
        #1 b_valid = 1'b0; push(5'd6, 32'hCC);
        #1 chk("rr_third_grant", {b_ready, a_ready}, 2'b01);
        @(negedge clk);
        chk("rr_wr3_data", write_data, 32'hCC);
        chk("cnt_two",     conflict_cnt, 16'd2);
        chk("fp_cnt_two",  fp_conflict_cnt, 2'd2);

        // Three more conflict cycles on x0: no RF writes, counter saturates in the 2-bit copy.
        #1 a_rd = 5'd0; a_data = '0; b_valid = 1'b1; b_rd = 5'd0; b_data = '0;
        @(negedge clk);
        chk("fp_cnt_sat", fp_conflict_cnt, 2'd3);
        @(negedge clk);
        @(negedge clk);
        chk("cnt_five",       conflict_cnt, 16'd5);
        chk("fp_cnt_hold",    fp_conflict_cnt, 2'd3);
        chk("x0_conflict_we", RegWr, 1'b0);
        #1 a_valid = 1'b0; b_valid = 1'b0;

        // Scoreboard: long issue to r7, stall until the B write of r7 commits.
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
        #1 chk("no_stall_clean", stall, 1'b0);
        @(negedge clk);
        chk("pend_r7_set", pending, 32'h0000_0080);
        #1 issue_long = 1'b0; rs1 = 5'd7; rs2 = 5'd2; rd = 5'd1;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77; push(5'd7, 32'h77);
        #1 chk("stall_rs1", stall, 1'b1);
        chk("b_only_ready", {b_ready, a_ready}, 2'b10);
        rs1 = 5'd0; rs2 = 5'd7;
        #1 chk("stall_rs2", stall, 1'b1);
        @(negedge clk);
        chk("b_commit_we",   RegWr, 1'b1);
        chk("pend_r7_hold",  pending, 32'h0000_0080);
        chk("stall_at_wr",   stall, 1'b1);
        #1 b_valid = 1'b0; rs2 = 5'd0; rd = 5'd7;
        #1 chk("stall_rd", stall, 1'b1);
        issue_valid = 1'b0;
        #1 chk("stall_no_issue", stall, 1'b0);
        issue_valid = 1'b1;
        @(negedge clk);
        chk("pend_r7_clear", pending, 32'd0);
        chk("stall_released", stall, 1'b0);

        // x0: B grant to r0 and long issue to r0 both leave no trace.
        #1 rd = 5'd0; issue_long = 1'b1; issue_rd = 5'd0;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF;
        #1 chk("x0_b_ready", b_ready, 1'b1);
        @(negedge clk);
        chk("x0_no_we",   RegWr, 1'b0);
        chk("x0_pending", pending, 32'd0);

        // Set/clear collision on r9: set wins.
        #1 b_valid = 1'b0; issue_rd = 5'd9;
        @(negedge clk);
        chk("pend_r9_set", pending, 32'h0000_0200);
        #1 issue_valid = 1'b0; issue_long = 1'b0;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99; push(5'd9, 32'h99);
        @(negedge clk);
        chk("r9_we",  RegWr, 1'b1);
        chk("r9_reg", write_reg, 5'd9);
        #1 b_valid = 1'b0; issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        chk("pend_r9_collide", pending, 32'h0000_0200);
        chk("r9_we_done",      RegWr, 1'b0);

        // Reset mid-operation: pending r12 and a loaded output stage are both dropped.
        #1 issue_rd = 5'd12; b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h12;
        @(negedge clk);
        chk("pend_r12_r9", pending, 32'h0000_1200);
        chk("r12_loaded",  RegWr, 1'b1);
        chk("r12_reg",     write_reg, 5'd12);
        #1 n_rst = 1'b0; issue_valid = 1'b0; issue_long = 1'b0; b_valid = 1'b0;
        #1 chk("midrst_we_killed", RegWr, 1'b0);
        @(negedge clk);
        chk("midrst_pending", pending, 32'd0);
        chk("midrst_cnt",     conflict_cnt, 16'd0);
        chk("midrst_wreg",    write_reg, 5'd0);
        chk("midrst_we",      RegWr, 1'b0);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
